bus_arbiter: RTL

Two-requester arbiter and steering switch that shares the single memory bus between the instruction cache and the data cache. It sits between both caches and the bus. It grants ownership through the same req/idle/grant handshake the caches already drive, with round-robin fairness on ties. It steers the owner's request channel onto the bus and the bus response channel back to the owner only.

---
 rtl/bus_pkg.sv | 32 +++
 rtl/bus_port_mux.sv | 86 ++++++++
 rtl/bus_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared memory-bus definitions: arbiter state/owner encodings and default
// bus widths used by both caches and the arbiter.
package bus_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 64;
    localparam int unsigned BUS_TAG_WIDTH  = 13;
    localparam int unsigned OWNER_W        = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // One-hot owner vector: bit 0 = icache, bit 1 = dcache, zero when idle.
    function automatic logic [OWNER_W-1:0] owner_onehot(input arb_state_e s);
        logic [OWNER_W-1:0] oh;
        oh = '0;
        case (s)
            GRANT_I: oh = 2'b01;
            GRANT_D: oh = 2'b10;
            default: oh = 2'b00;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/bus_port_mux.sv
// Combinational steering of the shared bus between two cache ports,
// selected by a one-hot owner vector; the non-owner sees all zeros.
module bus_port_mux #(
    parameter int unsigned DW = 64,
    parameter int unsigned TW = 13
) (
    input  logic [1:0]    owner_oh_i,
    // icache side
    input  logic          i_reqcyc_i,
    input  logic          i_respack_i,
    input  logic [DW-1:0] i_req_i,
    input  logic [TW-1:0] i_reqtag_i,
    output logic          i_respcyc_o,
    output logic          i_reqack_o,
    output logic [DW-1:0] i_resp_o,
    output logic [TW-1:0] i_resptag_o,
    // dcache side
    input  logic          d_reqcyc_i,
    input  logic          d_respack_i,
    input  logic [DW-1:0] d_req_i,
    input  logic [TW-1:0] d_reqtag_i,
    output logic          d_respcyc_o,
    output logic          d_reqack_o,
    output logic [DW-1:0] d_resp_o,
    output logic [TW-1:0] d_resptag_o,
    // shared bus side
    output logic          bus_reqcyc_o,
    output logic          bus_respack_o,
    output logic [DW-1:0] bus_req_o,
    output logic [TW-1:0] bus_reqtag_o,
    input  logic          bus_respcyc_i,
    input  logic          bus_reqack_i,
    input  logic [DW-1:0] bus_resp_i,
    input  logic [TW-1:0] bus_resptag_i
);
    import bus_pkg::*;

    logic own_i;
    logic own_d;

    assign own_i = owner_oh_i[0];
    assign own_d = owner_oh_i[1];

    // Request channel: owner's inputs onto the bus, zero when unowned.
    always_comb begin
        bus_reqcyc_o  = 1'b0;
        bus_respack_o = 1'b0;
        bus_req_o     = '0;
        bus_reqtag_o  = '0;
        if (own_i) begin
            bus_reqcyc_o  = i_reqcyc_i;
            bus_respack_o = i_respack_i;
            bus_req_o     = i_req_i;
            bus_reqtag_o  = i_reqtag_i;
        end else if (own_d) begin
            bus_reqcyc_o  = d_reqcyc_i;
            bus_respack_o = d_respack_i;
            bus_req_o     = d_req_i;
            bus_reqtag_o  = d_reqtag_i;
        end
    end

    // Response channel: bus outputs back to the owner only.
    always_comb begin
        i_respcyc_o = 1'b0;
        i_reqack_o  = 1'b0;
        i_resp_o    = '0;
        i_resptag_o = '0;
        d_respcyc_o = 1'b0;
        d_reqack_o  = 1'b0;
        d_resp_o    = '0;
        d_resptag_o = '0;
        if (own_i) begin
            i_respcyc_o = bus_respcyc_i;
            i_reqack_o  = bus_reqack_i;
            i_resp_o    = bus_resp_i;
            i_resptag_o = bus_resptag_i;
        end else if (own_d) begin
            d_respcyc_o = bus_respcyc_i;
            d_reqack_o  = bus_reqack_i;
            d_resp_o    = bus_resp_i;
            d_resptag_o = bus_resptag_i;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter sharing the memory bus between the
// icache and dcache; grants are registered, steering follows the state.
module bus_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH,
    parameter int unsigned BUS_TAG_WIDTH  = bus_pkg::BUS_TAG_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    // ownership handshake
    input  logic                      icache_busreq,
    input  logic                      dcache_busreq,
    input  logic                      icache_busidle,
    input  logic                      dcache_busidle,
    output logic                      icache_busgrant,
    output logic                      dcache_busgrant,
    // icache port
    input  logic                      icache_bus_reqcyc,
    input  logic                      icache_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] icache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_bus_reqtag,
    output logic                      icache_bus_respcyc,
    output logic                      icache_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] icache_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  icache_bus_resptag,
    // dcache port
    input  logic                      dcache_bus_reqcyc,
    input  logic                      dcache_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_bus_reqtag,
    output logic                      dcache_bus_respcyc,
    output logic                      dcache_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] dcache_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dcache_bus_resptag,
    // shared bus
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
    import bus_pkg::*;

    arb_state_e state_q, state_d;
    owner_e     last_owner_q, last_owner_d;
    logic       first_q, first_d;
    logic       grant_i_q, grant_d_q;
    logic [1:0] owner_oh;

    // State, tie-break history and first-granted-cycle flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_I;
            first_q      <= 1'b0;
            grant_i_q    <= 1'b0;
            grant_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            first_q      <= first_d;
            grant_i_q    <= (state_d == GRANT_I);
            grant_d_q    <= (state_d == GRANT_D);
        end
    end

    // Busidle in the first granted cycle belongs to the previous tenure.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        first_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (icache_busreq && dcache_busreq) begin
                    state_d = (last_owner_q == OWN_I) ? GRANT_D : GRANT_I;
                end else if (icache_busreq) begin
                    state_d = GRANT_I;
                end else if (dcache_busreq) begin
                    state_d = GRANT_D;
                end
                first_d = (state_d != IDLE);
            end
            GRANT_I: begin
                if (!first_q && icache_busidle) begin
                    state_d      = IDLE;
                    last_owner_d = OWN_I;
                end
            end
            GRANT_D: begin
                if (!first_q && dcache_busidle) begin
                    state_d      = IDLE;
                    last_owner_d = OWN_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign icache_busgrant = grant_i_q;
    assign dcache_busgrant = grant_d_q;
    assign owner_oh        = owner_onehot(state_q);

    bus_port_mux #(
        .DW (BUS_DATA_WIDTH),
        .TW (BUS_TAG_WIDTH)
    ) u_mux (
        .owner_oh_i    (owner_oh),
        .i_reqcyc_i    (icache_bus_reqcyc),
        .i_respack_i   (icache_bus_respack),
        .i_req_i       (icache_bus_req),
        .i_reqtag_i    (icache_bus_reqtag),
        .i_respcyc_o   (icache_bus_respcyc),
        .i_reqack_o    (icache_bus_reqack),
        .i_resp_o      (icache_bus_resp),
        .i_resptag_o   (icache_bus_resptag),
        .d_reqcyc_i    (dcache_bus_reqcyc),
        .d_respack_i   (dcache_bus_respack),
        .d_req_i       (dcache_bus_req),
        .d_reqtag_i    (dcache_bus_reqtag),
        .d_respcyc_o   (dcache_bus_respcyc),
        .d_reqack_o    (dcache_bus_reqack),
        .d_resp_o      (dcache_bus_resp),
        .d_resptag_o   (dcache_bus_resptag),
        .bus_reqcyc_o  (bus_reqcyc),
        .bus_respack_o (bus_respack),
        .bus_req_o     (bus_req),
        .bus_reqtag_o  (bus_reqtag),
        .bus_respcyc_i (bus_respcyc),
        .bus_reqack_i  (bus_reqack),
        .bus_resp_i    (bus_resp),
        .bus_resptag_i (bus_resptag)
    );

endmodule
